// File: rtl/izqader_serial_feeder_pkg.sv
// Shared types and encodings for the serial comparator feeder.
//   stateT        : feeder FSM states
//   RES_*         : final relation codes reported on result
//   YZ_*          : per-bit {y,z} step codes consumed by the comparator
package izqader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_EQ   = 2'b01;
    localparam logic [1:0] RES_A_GT = 2'b10;
    localparam logic [1:0] RES_B_GT = 2'b11;

    localparam logic [1:0] YZ_IDLE = 2'b00;
    localparam logic [1:0] YZ_EQ   = 2'b01;
    localparam logic [1:0] YZ_AGTB = 2'b10;
    localparam logic [1:0] YZ_BGTA = 2'b11;

endpackage

// File: rtl/izqader_serial_feeder_if.sv
// Handshake/bus bundle between the feeder and its environment.
//   start, a, b      : scan request and the two words to compare
//   step_ready       : downstream accepts the current step
//   step_valid, y, z : current step and its code
//   bit_idx          : index of the bit being presented
//   busy, done       : activity flag and end-of-scan pulse
//   result           : final relation
// modport master: the feeder side; modport slave: the environment side.
interface izqader_serial_feeder_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             step_ready;
    logic             step_valid;
    logic             y;
    logic             z;
    logic [CNT_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    logic [1:0]       result;

    modport master (
        input  start, a, b, step_ready,
        output step_valid, y, z, bit_idx, busy, done, result
    );

    modport slave (
        output start, a, b, step_ready,
        input  step_valid, y, z, bit_idx, busy, done, result
    );
endinterface

// File: rtl/izqader_serial_feeder_bit_code.sv
// Combinational per-bit step encoder.
//   aBit, bBit : one bit of word A and word B
//   yz         : {y,z} code (equal, A greater, B greater)
module izqader_bit_code (
    input  logic       aBit,
    input  logic       bBit,
    output logic [1:0] yz
);
    import izqader_pkg::*;

    always_comb begin
        yz = YZ_EQ;
        if (aBit && !bBit) begin
            yz = YZ_AGTB;
        end else if (!aBit && bBit) begin
            yz = YZ_BGTA;
        end
    end
endmodule

// File: rtl/izqader_serial_feeder.sv
// Serial feeder: captures two words on start and walks them MSB to LSB,
// presenting one {y,z} step per accepted handshake, then reports the relation.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : izqader_serial_feeder_if.master (start/a/b in, step handshake,
//                bit_idx, busy, done, result out)
// Build option: IZQADER_FULL_SCAN_EN -- when defined the scan always walks all
// WIDTH bits, latching the first difference; otherwise it stops early.
module izqader_serial_feeder #(
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    izqader_serial_feeder_if.master bus
);
    import izqader_pkg::*;

    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(WIDTH - 1);

    stateT            state;
    logic [WIDTH-1:0] capA;
    logic [WIDTH-1:0] capB;
    logic [CNT_W-1:0] bitIdx;
    logic [1:0]       yzReg;
    logic [1:0]       result;
    logic             stepValid;
    logic             busy;
    logic             done;

    logic [CNT_W-1:0] nextIdx;
    logic             nextA;
    logic             nextB;
    logic [1:0]       nextCode;
    logic [1:0]       startCode;
    logic             accept;
    logic             isDiff;
    logic [1:0]       diffRes;

    // Code for the following bit is prepared ahead so y/z stay registered.
    assign nextIdx = bitIdx - 1'b1;
    assign nextA   = |(capA & (WIDTH'(1) << nextIdx));
    assign nextB   = |(capB & (WIDTH'(1) << nextIdx));

    izqader_bit_code uNextCode (
        .aBit (nextA),
        .bBit (nextB),
        .yz   (nextCode)
    );

    izqader_bit_code uStartCode (
        .aBit (bus.a[WIDTH-1]),
        .bBit (bus.b[WIDTH-1]),
        .yz   (startCode)
    );

    assign accept  = stepValid && bus.step_ready;
    assign isDiff  = (yzReg != YZ_EQ);
    assign diffRes = (yzReg == YZ_AGTB) ? RES_A_GT : RES_B_GT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            capA      <= '0;
            capB      <= '0;
            bitIdx    <= '0;
            yzReg     <= YZ_IDLE;
            result    <= RES_NONE;
            stepValid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        capA      <= bus.a;
                        capB      <= bus.b;
                        bitIdx    <= TOP_IDX;
                        yzReg     <= startCode;
                        result    <= RES_NONE;
                        stepValid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (accept) begin
`ifdef IZQADER_FULL_SCAN_EN
                        if (isDiff && result == RES_NONE) begin
                            result <= diffRes;
                        end
                        if (bitIdx == '0) begin
                            if (!isDiff && result == RES_NONE) begin
                                result <= RES_EQ;
                            end
                            stepValid <= 1'b0;
                            yzReg     <= YZ_IDLE;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bitIdx <= nextIdx;
                            yzReg  <= nextCode;
                        end
`else
                        if (isDiff || bitIdx == '0) begin
                            result    <= isDiff ? diffRes : RES_EQ;
                            stepValid <= 1'b0;
                            yzReg     <= YZ_IDLE;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bitIdx <= nextIdx;
                            yzReg  <= nextCode;
                        end
`endif
                    end
                end
                DONE: begin
                    // Start is deliberately not sampled here.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.step_valid = stepValid;
    assign bus.y          = yzReg[1];
    assign bus.z          = yzReg[0];
    assign bus.bit_idx    = bitIdx;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.result     = result;

endmodule

// File: tb/tb_izqader_serial_feeder.sv
module tb_izqader_serial_feeder;
    localparam int WIDTH = 3;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef struct {
        int idx;
        int yz;
        int res;
    } stepT;

    typedef struct {
        int res;
        int n;
    } resT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    izqader_serial_feeder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    izqader_serial_feeder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    stepT stepQ[$];
    resT  resQ[$];
    int   tests = 0;
    int   fails = 0;
    int   stepCnt = 0;
    int   readyMode = 0;
    int   lastRes = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 1 = equal bit, 2 = A has the 1, 3 = B has the 1.
    function automatic int codeOf(input int av, input int bv, input int n);
        int ab;
        int bb;
        ab = (av >> n) & 1;
        bb = (bv >> n) & 1;
        if (ab == bb) return 1;
        return (ab == 1) ? 2 : 3;
    endfunction

    task automatic model(input int av, input int bv);
        int cur;
        int n;
        int c;
        cur = 0;
        n = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            c = codeOf(av, bv, i);
            stepQ.push_back('{i, c, cur});
            n++;
`ifdef IZQADER_FULL_SCAN_EN
            if (c != 1 && cur == 0) cur = (c == 2) ? 2 : 3;
`else
            if (c != 1) begin
                cur = (c == 2) ? 2 : 3;
                break;
            end
`endif
        end
        if (cur == 0) cur = 1;
        resQ.push_back('{cur, n});
        lastRes = cur;
    endtask

    always @(negedge clk) begin
        case (readyMode)
            0:       bus.step_ready = 1'b1;
            1:       bus.step_ready = 1'($urandom_range(0, 1));
            default: bus.step_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        stepT e;
        resT  r;
        if (!rst_n) begin
            stepCnt = 0;
        end else begin
            if (bus.step_valid) begin
                if (stepQ.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    e = stepQ[0];
                    chk("step_idx", int'(bus.bit_idx), e.idx);
                    chk("step_yz", int'({bus.y, bus.z}), e.yz);
                    chk("step_result", int'(bus.result), e.res);
                    chk("step_busy", int'(bus.busy), 1);
                    if (bus.step_ready) begin
                        void'(stepQ.pop_front());
                        stepCnt++;
                    end
                end
            end
            if (bus.done) begin
                if (resQ.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = resQ.pop_front();
                    chk("done_result", int'(bus.result), r.res);
                    chk("done_step_count", stepCnt, r.n);
                    chk("done_yz_idle", int'({bus.step_valid, bus.y, bus.z}), 0);
                end
                stepCnt = 0;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_step_valid"}, int'(bus.step_valid), 0);
        chk({tag, "_y"}, int'(bus.y), 0);
        chk({tag, "_z"}, int'(bus.z), 0);
        chk({tag, "_bit_idx"}, int'(bus.bit_idx), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_result"}, int'(bus.result), 0);
    endtask

    // Called at a negedge; inDone means the current cycle is the DONE cycle.
    task automatic startTxn(input int av, input int bv, input bit inDone);
        model(av, bv);
        bus.a = WIDTH'(av);
        bus.b = WIDTH'(bv);
        bus.start = 1'b1;
        if (inDone) begin
            @(negedge clk);
            chk("start_in_done_ignored", int'(bus.step_valid), 0);
            chk("idle_after_done", int'(bus.busy), 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("valid_latency1", int'(bus.step_valid), 1);
    endtask

    task automatic waitDone(input bit glitch);
        for (int c = 0; c < 300; c++) begin
            if (bus.done) begin
                bus.start = 1'b0;
                return;
            end
            if (glitch) begin
                bus.a = WIDTH'($urandom);
                bus.b = WIDTH'($urandom);
                bus.start = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("done_timeout", 0, 1);
    endtask

    task automatic runTxn(input int av, input int bv);
        startTxn(av, bv, 1'b0);
        waitDone(1'b1);
        @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_valid", int'(bus.step_valid), 0);
        chk("result_held", int'(bus.result), lastRes);
    endtask

    initial begin
        bit inDone;
        int av;
        int bv;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        readyMode = 0;
        rst_n = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        runTxn(3'b011, 3'b001);
        runTxn(3'b010, 3'b110);
        runTxn(3'b101, 3'b101);
        runTxn(3'b100, 3'b010);

        // Stall on the first step.
        readyMode = 2;
        startTxn(3'b011, 3'b001, 1'b0);
        repeat (5) @(negedge clk);
        chk("stall_valid", int'(bus.step_valid), 1);
        chk("stall_idx", int'(bus.bit_idx), WIDTH - 1);
        readyMode = 0;
        waitDone(1'b0);
        @(negedge clk);

        // Asynchronous reset mid-scan, after the first accepted step.
        startTxn(3'b011, 3'b001, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        stepQ.delete();
        resQ.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", int'(bus.busy), 0);
        runTxn(3'b110, 3'b111);

        // Randomized traffic with random backpressure and back-to-back starts.
        readyMode = 1;
        inDone = 1'b0;
        for (int t = 0; t < 40; t++) begin
            av = int'($urandom_range(0, (1 << WIDTH) - 1));
            bv = ($urandom_range(0, 3) == 0) ? av : int'($urandom_range(0, (1 << WIDTH) - 1));
            startTxn(av, bv, inDone);
            waitDone(1'b1);
            inDone = ($urandom_range(0, 1) == 1);
            if (!inDone) begin
                @(negedge clk);
                chk("rand_result_held", int'(bus.result), lastRes);
            end
        end
        if (inDone) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queues_drained", stepQ.size() + resQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
